max_pool_2x2: RTL and testbench
===============================

Name: max_pool_2x2

Overview:
- Streaming 2x2, stride-2 max-pool stage directly downstream of the post-MAC bias/ReLU/shift stage.
- Consumes the six 16-bit conv1 channel results, one pixel per valid beat, in raster order.
- Emits one pooled 6-channel pixel per 2x2 window, with its linear output address, for write-back to feature-map memory.
- Default geometry: 24x24 conv1 map to 12x12 pooled map.

Parameters:
- ROW_W, 24, input row width in pixels; even, at least 2.
- COL_H, 24, input column height in rows; even, at least 2.
- DATA_W, 16, channel word width; two's-complement.
- ADDR_W, 8, width of out_addr; must satisfy 2^ADDR_W >= (ROW_W/2)*(COL_H/2).

Ports:
- clk  in  1  Single clock; all logic rising-edge.
- reset_n  in  1  Asynchronous, active-low reset.
- start  in  1  One-cycle pulse; begins a new frame. Sampled only in IDLE.
- in_valid  in  1  in_0..in_5 hold the next raster pixel this cycle.
- in_0..in_5  in  DATA_W each  Channel 0..5 values for the current pixel; signed.
- out_valid  out  1  One-cycle pulse; out_0..out_5 and out_addr are valid.
- out_0..out_5  out  DATA_W each  Pooled maximum per channel; signed.
- out_addr  out  ADDR_W  Pooled pixel index: (row/2)*(ROW_W/2) + col/2.
- busy  out  1  High in RUN.
- frame_done  out  1  One-cycle pulse after the last pooled pixel of a frame.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - col, row, hold registers, line buffer, and all outputs clear to 0.
  - A reset mid-frame abandons the frame; no partial output is produced.
- States:
  - IDLE: busy=0. A start pulse clears col and row and moves to RUN. in_valid is ignored in IDLE.
  - RUN: busy=1. Each in_valid beat is accepted; there is no backpressure. Cycles with in_valid=0 are stalls with no state change. start is ignored in RUN.
  - DONE: lasts exactly 1 cycle. frame_done=1, then return to IDLE.
- Counters:
  - col runs 0..ROW_W-1 and wraps to 0.
  - On the wrap, row increments (0..COL_H-1).
  - The beat at row=COL_H-1, col=ROW_W-1 moves the state to DONE after that beat is processed.
- Per-channel datapath (identical for channels 0..5):
  - Even col: hold_c <= in_c.
  - Odd col, even row: linebuf_c[col>>1] <= smax(hold_c, in_c).
  - Odd col, odd row: out_c <= smax(linebuf_c[col>>1], smax(hold_c, in_c)). Also out_addr <= (row>>1)*(ROW_W/2) + (col>>1), and out_valid <= 1.
- Arithmetic:
  - smax is a signed DATA_W comparison; on a tie either operand is returned (values are equal).
  - No widening or saturation; outputs are an exact copy of one input word.
- Line buffer: ROW_W/2 entries x 6 channels x DATA_W, flop-based. Contents are not cleared between frames; each entry is always written on the even row before it is read on the odd row.
- Latency and hold:
  - out_valid is asserted in the cycle after the accepting beat (1-cycle latency).
  - out_valid is high for exactly 1 cycle.
  - out_0..5 and out_addr hold their last value until the next pooled pixel.
- Output count:
  - Exactly (ROW_W/2)*(COL_H/2) out_valid pulses per frame (144 by default).
  - frame_done is asserted in the same cycle as the final out_valid, since DONE is entered on the last beat.
- Back-to-back frames: a start in the cycle after frame_done (IDLE) is accepted, giving zero-gap operation.

Test Plan:
- Reset, then start. Drive 576 beats with all channels = (row*24+col). Expect 144 out_valid pulses. Pixel k has out_c = (2*(k/12)+1)*24 + 2*(k%12) + 1 and out_addr = k. frame_done coincides with the 144th pulse.
- Signed compare: window values -5, -3, -8, -1 on channel 2 → out_2 = -1. Window 0x7FFF, 0x8000, 0, 1 → 0x7FFF.
- Stalls: insert random in_valid=0 gaps (1–5 cycles) into the first test's stream. Outputs and addresses must be identical and only the cycle timing shifts; busy stays high throughout.
- in_valid and start misuse:
  - in_valid pulses while IDLE produce no output and no counter change.
  - A start pulse at beat 100 of a frame is ignored; the frame completes normally with 144 outputs.
- Reset mid-frame: assert reset_n=0 after 300 beats. All outputs read 0 and busy=0 immediately (asynchronously). A new start plus 576 beats yields a correct 144-output frame.
- Small geometry, ROW_W=4, COL_H=2: input rows [1,9,2,3] / [4,5,7,8] → 2 outputs, values 9 then 8, addresses 0 then 1. The second output coincides with frame_done.

Source files
------------

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: streaming 2x2 / stride-2 max-pool over six signed channels.
// Pixels arrive in raster order, one per in_valid beat, with no backpressure.
// Even-column pixels are held. On even rows the horizontal pair maximum goes
// into a line buffer. On odd rows it is combined with the stored pair maximum
// to produce one pooled pixel and its linear output address.
module max_pool_2x2 #(
    parameter int ROW_W  = 24,
    parameter int COL_H  = 24,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_0,
    input  logic signed [DATA_W-1:0] in_1,
    input  logic signed [DATA_W-1:0] in_2,
    input  logic signed [DATA_W-1:0] in_3,
    input  logic signed [DATA_W-1:0] in_4,
    input  logic signed [DATA_W-1:0] in_5,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_0,
    output logic signed [DATA_W-1:0] out_1,
    output logic signed [DATA_W-1:0] out_2,
    output logic signed [DATA_W-1:0] out_3,
    output logic signed [DATA_W-1:0] out_4,
    output logic signed [DATA_W-1:0] out_5,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int N_CH   = 6;
    localparam int HALF_W = ROW_W / 2;
    localparam int COL_CW = (ROW_W > 2) ? $clog2(ROW_W) : 1;
    localparam int ROW_CW = (COL_H > 2) ? $clog2(COL_H) : 1;
    localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [COL_CW-1:0] COL_LAST = COL_CW'(ROW_W - 1);
    localparam logic [ROW_CW-1:0] ROW_LAST = ROW_CW'(COL_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [COL_CW-1:0]   col_q, col_d;
    logic [ROW_CW-1:0]   row_q, row_d;
    logic                out_valid_q;
    logic [ADDR_W-1:0]   out_addr_q;

    logic                accept;
    logic                pool_fire;
    logic [LB_AW-1:0]    lb_idx;
    logic [ADDR_W-1:0]   addr_calc;

    logic signed [DATA_W-1:0] in_w  [N_CH];
    logic signed [DATA_W-1:0] out_w [N_CH];

    // Signed maximum; on a tie both operands are equal so either is fine.
    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign in_w[0] = in_0;
    assign in_w[1] = in_1;
    assign in_w[2] = in_2;
    assign in_w[3] = in_3;
    assign in_w[4] = in_4;
    assign in_w[5] = in_5;

    // Beats are only consumed in RUN; IDLE and DONE ignore in_valid.
    assign accept    = (state_q == S_RUN) && in_valid;
    // Odd column of an odd row closes a 2x2 window.
    assign pool_fire = accept && col_q[0] && row_q[0];
    assign lb_idx    = LB_AW'(col_q >> 1);
    assign addr_calc = ADDR_W'(row_q >> 1) * ADDR_W'(HALF_W) + ADDR_W'(col_q >> 1);

    // State and raster counters register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Next-state and raster counter logic; the last beat of a frame goes to DONE.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + ROW_CW'(1);
                        end
                    end else begin
                        col_d = col_q + COL_CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output strobe is a single-cycle pulse; the address holds until the next window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
        end else begin
            out_valid_q <= pool_fire;
            if (pool_fire) begin
                out_addr_q <= addr_calc;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic signed [DATA_W-1:0] hold_q;
            logic signed [DATA_W-1:0] out_q;
            logic signed [DATA_W-1:0] lb_q [HALF_W];
            logic signed [DATA_W-1:0] pair_max;

            assign pair_max = smax(hold_q, in_w[gi]);

            // Per-channel hold, line buffer and pooled result registers.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hold_q <= '0;
                    out_q  <= '0;
                    for (int i = 0; i < HALF_W; i++) begin
                        lb_q[i] <= '0;
                    end
                end else if (accept) begin
                    if (!col_q[0]) begin
                        hold_q <= in_w[gi];
                    end else if (!row_q[0]) begin
                        lb_q[lb_idx] <= pair_max;
                    end else begin
                        out_q <= smax(lb_q[lb_idx], pair_max);
                    end
                end
            end

            assign out_w[gi] = out_q;
        end
    endgenerate

    assign out_0      = out_w[0];
    assign out_1      = out_w[1];
    assign out_2      = out_w[2];
    assign out_3      = out_w[3];
    assign out_4      = out_w[4];
    assign out_5      = out_w[5];
    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign busy       = (state_q == S_RUN);
    assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_max_pool_2x2.sv
// Testbench for max_pool_2x2: randomized frames against an image-level
// max-pool model, with expected pixels queued and checked by a monitor.
module tb_max_pool_2x2;

    localparam int W    = 24;
    localparam int H    = 24;
    localparam int NOUT = (W / 2) * (H / 2);

    typedef struct packed {
        logic [5:0][15:0] v;
        logic [7:0]       addr;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main (24x24) instance signals
    logic               reset_n, start, in_valid;
    logic signed [15:0] in_v  [6];
    logic               out_valid, busy, frame_done;
    logic signed [15:0] out_v [6];
    logic [7:0]         out_addr;

    // Small (4x2) instance signals
    logic               s_start, s_in_valid;
    logic signed [15:0] s_in;
    logic               s_out_valid, s_busy, s_done;
    logic signed [15:0] s_out [6];
    logic [1:0]         s_addr;

    exp_t q[$];
    exp_t sq[$];
    exp_t me, se;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   img [H][W][6];
    logic signed [15:0] got2 [NOUT];
    int   got_idx;
    bit   ok;

    max_pool_2x2 #(.ROW_W(W), .COL_H(H), .DATA_W(16), .ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_0(in_v[0]), .in_1(in_v[1]), .in_2(in_v[2]),
        .in_3(in_v[3]), .in_4(in_v[4]), .in_5(in_v[5]),
        .out_valid(out_valid),
        .out_0(out_v[0]), .out_1(out_v[1]), .out_2(out_v[2]),
        .out_3(out_v[3]), .out_4(out_v[4]), .out_5(out_v[5]),
        .out_addr(out_addr), .busy(busy), .frame_done(frame_done)
    );

    max_pool_2x2 #(.ROW_W(4), .COL_H(2), .DATA_W(16), .ADDR_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(s_start), .in_valid(s_in_valid),
        .in_0(s_in), .in_1(s_in), .in_2(s_in), .in_3(s_in), .in_4(s_in), .in_5(s_in),
        .out_valid(s_out_valid),
        .out_0(s_out[0]), .out_1(s_out[1]), .out_2(s_out[2]),
        .out_3(s_out[3]), .out_4(s_out[4]), .out_5(s_out[5]),
        .out_addr(s_addr), .busy(s_busy), .frame_done(s_done)
    );

    // Main monitor: every out_valid pops one expected pooled pixel.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got out_valid=1 addr=%0d, required no output", out_addr);
                end else begin
                    me = q.pop_front();
                    ok = (out_addr == me.addr) && (frame_done == me.last);
                    for (int c = 0; c < 6; c++) ok = ok && (out_v[c] == me.v[c]);
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL pool_out: got addr=%0d done=%0b ch0=%0d ch2=%0d ch5=%0d, required addr=%0d done=%0b ch0=%0d ch2=%0d ch5=%0d",
                                 out_addr, frame_done, out_v[0], out_v[2], out_v[5],
                                 me.addr, me.last, $signed(me.v[0]), $signed(me.v[2]), $signed(me.v[5]));
                    end
                    $display("out k=%0d addr=%0d ch2=%0d done=%0b", got_idx, out_addr, out_v[2], frame_done);
                end
                if (got_idx < NOUT) got2[got_idx] = out_v[2];
                got_idx++;
            end else if (frame_done) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_done: got frame_done=1 without out_valid, required 0");
            end
        end
    end

    // Small-geometry monitor.
    always @(negedge clk) begin
        if (reset_n && s_out_valid) begin
            n_checks++;
            if (sq.size() == 0) begin
                n_fail++;
                $display("FAIL small_unexpected: got out_valid=1 addr=%0d, required no output", s_addr);
            end else begin
                se = sq.pop_front();
                ok = ({6'd0, s_addr} == se.addr) && (s_done == se.last);
                for (int c = 0; c < 6; c++) ok = ok && (s_out[c] == se.v[c]);
                if (!ok) begin
                    n_fail++;
                    $display("FAIL small_out: got addr=%0d done=%0b val=%0d, required addr=%0d done=%0b val=%0d",
                             s_addr, s_done, s_out[0], se.addr, se.last, $signed(se.v[0]));
                end
                $display("small out addr=%0d val=%0d done=%0b", s_addr, s_out[0], s_done);
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // mode 0: ramp row*W+col on all channels; mode 1: random plus signed corner windows.
    task automatic fill_img(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int ch = 0; ch < 6; ch++)
                    img[r][c][ch] = (mode == 0) ? (r * W + c) : (int'($urandom_range(0, 65535)) - 32768);
        if (mode == 1) begin
            img[0][0][2] = -5;     img[0][1][2] = -3;
            img[1][0][2] = -8;     img[1][1][2] = -1;
            img[0][2][2] = 32767;  img[0][3][2] = -32768;
            img[1][2][2] = 0;      img[1][3][2] = 1;
        end
    endtask

    // Reference: max over each 2x2 window of the stored image.
    task automatic push_frame_exp();
        exp_t e;
        int r, c, m;
        for (int k = 0; k < NOUT; k++) begin
            r = k / (W / 2);
            c = k % (W / 2);
            e.addr = 8'(k);
            e.last = (k == NOUT - 1);
            for (int ch = 0; ch < 6; ch++) begin
                m = img[2*r][2*c][ch];
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (img[2*r+dr][2*c+dc][ch] > m) m = img[2*r+dr][2*c+dc][ch];
                e.v[ch] = 16'(m);
            end
            q.push_back(e);
        end
    endtask

    task automatic drive_frame(input bit stalls, input int start_at, input int abort_at);
        int r, c, n;
        got_idx = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int b = 0; b < W * H; b++) begin
            if (b == abort_at) begin
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            if (stalls && $urandom_range(0, 3) == 0) begin
                n = $urandom_range(1, 5);
                in_valid = 1'b0;
                start    = 1'b0;
                repeat (n) begin
                    check("busy_stall", int'(busy), 1);
                    @(negedge clk);
                end
            end
            r = b / W;
            c = b % W;
            in_valid = 1'b1;
            for (int ch = 0; ch < 6; ch++) in_v[ch] = 16'(img[r][c][ch]);
            start = (b == start_at);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        check(name, q.size(), 0);
        check({name, "_count"}, got_idx, NOUT);
        check({name, "_idle"}, int'(busy), 0);
    endtask

    int small_vals [8] = '{1, 9, 2, 3, 4, 5, 7, 8};

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        s_start = 1'b0; s_in_valid = 1'b0; s_in = '0;
        for (int ch = 0; ch < 6; ch++) in_v[ch] = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(frame_done), 0);
        check("reset_addr", int'(out_addr), 0);
        check("reset_out0", int'(out_v[0]), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Ramp frame
        fill_img(0); push_frame_exp();
        drive_frame(1'b0, -1, -1);
        drain("ramp");
        check("ramp_first", int'(got2[0]), 25);
        check("ramp_last", int'(got2[NOUT-1]), 23 * 24 + 23);

        // Ramp frame with random stalls
        push_frame_exp();
        drive_frame(1'b1, -1, -1);
        drain("stall");

        // Random frame with signed corner windows
        fill_img(1); push_frame_exp();
        drive_frame(1'b0, -1, -1);
        drain("random");
        check("signed_neg", int'(got2[0]), -1);
        check("signed_ext", int'(got2[1]), 32767);

        // in_valid while IDLE must do nothing
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            for (int ch = 0; ch < 6; ch++) in_v[ch] = 16'($urandom);
            check("idle_busy", int'(busy), 0);
        end
        in_valid = 1'b0;

        // Stray start mid-frame is ignored
        fill_img(1); push_frame_exp();
        drive_frame(1'b1, 100, -1);
        drain("start_mid");

        // Reset after 300 beats
        fill_img(1); push_frame_exp();
        drive_frame(1'b0, -1, 300);
        check("abort_remaining", q.size(), NOUT - 72);
        #2 reset_n = 1'b0;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_valid", int'(out_valid), 0);
        check("async_addr", int'(out_addr), 0);
        for (int ch = 0; ch < 6; ch++) check("async_out", int'(out_v[ch]), 0);
        q.delete();
        @(negedge clk); reset_n = 1'b1;
        fill_img(1); push_frame_exp();
        drive_frame(1'b1, -1, -1);
        drain("post_reset");

        // Small geometry 4x2
        for (int k = 0; k < 2; k++) begin
            e.addr = 8'(k);
            e.last = (k == 1);
            for (int ch = 0; ch < 6; ch++) e.v[ch] = (k == 0) ? 16'd9 : 16'd8;
            sq.push_back(e);
        end
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        for (int b = 0; b < 8; b++) begin
            s_in_valid = 1'b1;
            s_in = 16'(small_vals[b]);
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        for (int i = 0; i < 10 && sq.size() != 0; i++) @(negedge clk);
        check("small_drain", sq.size(), 0);
        check("small_idle", int'(s_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
